// File: rtl/layer_io_pkg.sv
// Shared defaults, FSM state type and address-width helper for the layer I/O bridge.
package layer_io_pkg;

    localparam int unsigned N_DEFAULT     = 8;
    localparam int unsigned M_DEFAULT     = 8;
    localparam int unsigned WIDTH_DEFAULT = 12;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StRecv,
        StDone
    } state_e;

    function automatic int unsigned addr_width(input int unsigned n, input int unsigned m);
        int unsigned mx;
        mx = (n > m) ? n : m;
        return (mx > 1) ? $clog2(mx) : 1;
    endfunction

endpackage

// File: rtl/vec_buffer.sv
// Register file with synchronous write and registered read; out-of-range accesses are dropped.
module vec_buffer #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned WIDTH  = 12,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Storage carries no reset; only the read register does.
    always_ff @(posedge clk) begin
        if (i_wr_en && (32'(i_wr_addr) < DEPTH)) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_data <= '0;
        end else if (32'(i_rd_addr) < DEPTH) begin
            r_rd_data <= r_mem[i_rd_addr];
        end else begin
            r_rd_data <= '0;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/layer_io_bridge.sv
// Host-loaded vector streamed out to a layer, with the layer's result captured back for host reads.
module layer_io_bridge
    import layer_io_pkg::*;
#(
    parameter int unsigned N     = N_DEFAULT,
    parameter int unsigned M     = M_DEFAULT,
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    localparam int unsigned AW   = addr_width(N, M)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    host_wr_en,
    input  logic [AW-1:0]           host_addr,
    input  logic signed [WIDTH-1:0] host_wr_data,
    input  logic                    start,
    output logic signed [WIDTH-1:0] host_rd_data,
    output logic                    busy,
    output logic                    done,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [WIDTH-1:0] m_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [WIDTH-1:0] s_data
);

    localparam int unsigned TW = $clog2(N + 1);
    localparam int unsigned RW = $clog2(M + 1);
    localparam logic [TW-1:0] TX_LAST = TW'(N - 1);
    localparam logic [RW-1:0] RX_END  = RW'(M);

    state_e        r_state, w_state_d;
    logic [TW-1:0] r_tx, w_tx_d;
    logic [RW-1:0] r_rx, w_rx_d;
    logic          w_tx_fire, w_rx_fire, w_host_wr;

    assign busy      = (r_state == StSend) || (r_state == StRecv);
    assign done      = (r_state == StDone);
    assign m_valid   = (r_state == StSend);
    assign s_ready   = busy && (r_rx < RX_END);
    assign w_tx_fire = m_valid && m_ready;
    assign w_rx_fire = s_valid && s_ready;
    assign w_host_wr = host_wr_en && !busy;

    always_comb begin
        w_state_d = r_state;
        w_tx_d    = r_tx;
        w_rx_d    = r_rx;
        unique case (r_state)
            StIdle, StDone: begin
                if (start) begin
                    w_state_d = StSend;
                    w_tx_d    = '0;
                    w_rx_d    = '0;
                end
            end
            StSend: begin
                if (w_rx_fire) begin
                    w_rx_d = r_rx + 1'b1;
                end
                if (w_tx_fire) begin
                    w_tx_d = r_tx + 1'b1;
                    if (r_tx == TX_LAST) begin
                        // Receive side may already have finished while sending overlapped.
                        w_state_d = (w_rx_d == RX_END) ? StDone : StRecv;
                    end
                end
            end
            StRecv: begin
                if (w_rx_fire) begin
                    w_rx_d = r_rx + 1'b1;
                    if (w_rx_d == RX_END) begin
                        w_state_d = StDone;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
            r_tx    <= '0;
            r_rx    <= '0;
        end else begin
            r_state <= w_state_d;
            r_tx    <= w_tx_d;
            r_rx    <= w_rx_d;
        end
    end

    // Read address follows the next tx index so m_data is ready as the beat is presented.
    vec_buffer #(
        .DEPTH  (N),
        .WIDTH  (WIDTH),
        .ADDR_W (AW)
    ) u_in_buf (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_host_wr),
        .i_wr_addr (host_addr),
        .i_wr_data (host_wr_data),
        .i_rd_addr (AW'(w_tx_d)),
        .o_rd_data (m_data)
    );

    vec_buffer #(
        .DEPTH  (M),
        .WIDTH  (WIDTH),
        .ADDR_W (AW)
    ) u_res_buf (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_rx_fire),
        .i_wr_addr (AW'(r_rx)),
        .i_wr_data (s_data),
        .i_rd_addr (host_addr),
        .o_rd_data (host_rd_data)
    );

endmodule
